// File: rtl/mac_wb_pkg.sv
// Shared types for the MAC Wishbone arbiter.
// Widths, arbiter state encoding and grant codes.
package mac_wb_pkg;

  localparam int MAC_AW      = 2;
  localparam int MAC_DW      = 8;
  localparam int MAC_TIMEOUT = 255;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT_A = 2'd1,
    S_GRANT_B = 2'd2,
    S_ABORT   = 2'd3
  } arb_state_e;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_A    = 2'b01;
  localparam logic [1:0] GNT_B    = 2'b10;

  localparam logic LAST_A = 1'b0;
  localparam logic LAST_B = 1'b1;

endpackage

// File: rtl/mac_arb_wdt.sv
// Bus-hang watchdog for the MAC arbiter.
// Ports: clk, rst, clr_i, en_i in; expired_o out.
module mac_arb_wdt #(
  parameter int TIMEOUT = 255,
  parameter int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign expired_o = (cnt_q == CW'(TIMEOUT));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mac_wb_arbiter.sv
// Two-master round-robin, cyc-locked arbiter for the
// MAC Wishbone slave port. Masters A/B (i_x_wb_*,
// o_x_wb_*), slave side o_wb_*/i_wb_*, o_grant one-hot.
// Optional MAC_ARB_TIMEOUT_EN adds an ack watchdog.
module mac_wb_arbiter
  import mac_wb_pkg::*;
#(
  parameter int AW      = MAC_AW,
  parameter int DW      = MAC_DW,
  parameter int TIMEOUT = MAC_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_a_wb_cyc,
  input  logic          i_a_wb_stb,
  input  logic          i_a_wb_we,
  input  logic [AW-1:0] i_a_wb_addr,
  input  logic [DW-1:0] i_a_wb_data,
  output logic          o_a_wb_ack,
  output logic          o_a_wb_stall,
  output logic          o_a_wb_err,
  output logic [DW-1:0] o_a_wb_data,
  input  logic          i_b_wb_cyc,
  input  logic          i_b_wb_stb,
  input  logic          i_b_wb_we,
  input  logic [AW-1:0] i_b_wb_addr,
  input  logic [DW-1:0] i_b_wb_data,
  output logic          o_b_wb_ack,
  output logic          o_b_wb_stall,
  output logic          o_b_wb_err,
  output logic [DW-1:0] o_b_wb_data,
  output logic          o_wb_cyc,
  output logic          o_wb_stb,
  output logic          o_wb_we,
  output logic [AW-1:0] o_wb_addr,
  output logic [DW-1:0] o_wb_data,
  input  logic          i_wb_ack,
  input  logic          i_wb_stall,
  input  logic [DW-1:0] i_wb_data,
  output logic [1:0]    o_grant
);

  arb_state_e state_q;
  arb_state_e state_d;
  logic       last_q;
  logic       last_d;
  logic       expired;

`ifdef MAC_ARB_TIMEOUT_EN
  logic owner_q;
  logic owner_d;
  logic in_grant;
  logic wdt_clr;

  assign in_grant = (state_q == S_GRANT_A) ||
                    (state_q == S_GRANT_B);
  // Restart on every new grant and on any ack.
  assign wdt_clr  = !in_grant || i_wb_ack ||
                    (state_d != state_q);

  mac_arb_wdt #(
    .TIMEOUT (TIMEOUT)
  ) u_wdt (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (wdt_clr),
    .en_i      (in_grant),
    .expired_o (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= LAST_A;
    end else begin
      owner_q <= owner_d;
    end
  end
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT;
  assign expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      last_q  <= LAST_B;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
`ifdef MAC_ARB_TIMEOUT_EN
    owner_d = owner_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (i_a_wb_cyc &&
            (!i_b_wb_cyc || last_q == LAST_B)) begin
          state_d = S_GRANT_A;
        end else if (i_b_wb_cyc) begin
          state_d = S_GRANT_B;
        end
      end
      S_GRANT_A: begin
        if (!i_a_wb_cyc) begin
          last_d  = LAST_A;
          state_d = i_b_wb_cyc ? S_GRANT_B : S_IDLE;
        end else if (expired) begin
          state_d = S_ABORT;
`ifdef MAC_ARB_TIMEOUT_EN
          owner_d = LAST_A;
`endif
        end
      end
      S_GRANT_B: begin
        if (!i_b_wb_cyc) begin
          last_d  = LAST_B;
          state_d = i_a_wb_cyc ? S_GRANT_A : S_IDLE;
        end else if (expired) begin
          state_d = S_ABORT;
`ifdef MAC_ARB_TIMEOUT_EN
          owner_d = LAST_B;
`endif
        end
      end
      S_ABORT: begin
`ifdef MAC_ARB_TIMEOUT_EN
        // Wait for the aborted master to end its cycle.
        if ((owner_q == LAST_A && !i_a_wb_cyc) ||
            (owner_q == LAST_B && !i_b_wb_cyc)) begin
          last_d  = owner_q;
          state_d = S_IDLE;
        end
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Read data is broadcast; only the ack is steered.
  assign o_a_wb_data = i_wb_data;
  assign o_b_wb_data = i_wb_data;

  always_comb begin
    o_wb_cyc     = 1'b0;
    o_wb_stb     = 1'b0;
    o_wb_we      = 1'b0;
    o_wb_addr    = '0;
    o_wb_data    = '0;
    o_a_wb_ack   = 1'b0;
    o_a_wb_stall = 1'b1;
    o_a_wb_err   = 1'b0;
    o_b_wb_ack   = 1'b0;
    o_b_wb_stall = 1'b1;
    o_b_wb_err   = 1'b0;
    o_grant      = GNT_NONE;
    unique case (state_q)
      S_GRANT_A: begin
        o_wb_cyc     = i_a_wb_cyc;
        o_wb_stb     = i_a_wb_stb;
        o_wb_we      = i_a_wb_we;
        o_wb_addr    = i_a_wb_addr;
        o_wb_data    = i_a_wb_data;
        o_a_wb_ack   = i_wb_ack;
        o_a_wb_stall = i_wb_stall;
        o_a_wb_err   = expired && i_a_wb_cyc;
        o_grant      = GNT_A;
      end
      S_GRANT_B: begin
        o_wb_cyc     = i_b_wb_cyc;
        o_wb_stb     = i_b_wb_stb;
        o_wb_we      = i_b_wb_we;
        o_wb_addr    = i_b_wb_addr;
        o_wb_data    = i_b_wb_data;
        o_b_wb_ack   = i_wb_ack;
        o_b_wb_stall = i_wb_stall;
        o_b_wb_err   = expired && i_b_wb_cyc;
        o_grant      = GNT_B;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mac_wb_arbiter.sv
// Directed-vector bench for mac_wb_arbiter.
// Cycle trace table plus a watchdog sequence.
module tb_mac_wb_arbiter;

  localparam bit O = 1'b0;
  localparam bit I = 1'b1;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_cyc, a_stb, a_we;
  logic [1:0] a_addr;
  logic [7:0] a_wd;
  logic       a_ack, a_stall, a_err;
  logic [7:0] a_rd;
  logic       b_cyc, b_stb, b_we;
  logic [1:0] b_addr;
  logic [7:0] b_wd;
  logic       b_ack, b_stall, b_err;
  logic [7:0] b_rd;
  logic       wb_cyc, wb_stb, wb_we;
  logic [1:0] wb_addr;
  logic [7:0] wb_wd;
  logic       s_ack, s_stall;
  logic [7:0] s_rd;
  logic [1:0] grant;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mac_wb_arbiter #(.TIMEOUT(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_a_wb_cyc   (a_cyc),
    .i_a_wb_stb   (a_stb),
    .i_a_wb_we    (a_we),
    .i_a_wb_addr  (a_addr),
    .i_a_wb_data  (a_wd),
    .o_a_wb_ack   (a_ack),
    .o_a_wb_stall (a_stall),
    .o_a_wb_err   (a_err),
    .o_a_wb_data  (a_rd),
    .i_b_wb_cyc   (b_cyc),
    .i_b_wb_stb   (b_stb),
    .i_b_wb_we    (b_we),
    .i_b_wb_addr  (b_addr),
    .i_b_wb_data  (b_wd),
    .o_b_wb_ack   (b_ack),
    .o_b_wb_stall (b_stall),
    .o_b_wb_err   (b_err),
    .o_b_wb_data  (b_rd),
    .o_wb_cyc     (wb_cyc),
    .o_wb_stb     (wb_stb),
    .o_wb_we      (wb_we),
    .o_wb_addr    (wb_addr),
    .o_wb_data    (wb_wd),
    .i_wb_ack     (s_ack),
    .i_wb_stall   (s_stall),
    .i_wb_data    (s_rd),
    .o_grant      (grant)
  );

  typedef struct {
    logic       rst;
    logic       ac, as, aw;
    logic [1:0] aa;
    logic [7:0] ad;
    logic       bc, bs, bw;
    logic [1:0] ba;
    logic [7:0] bd;
    logic       ack, stl;
    logic [7:0] rd;
    logic [1:0] g;
    logic       c, s, w;
    logic [1:0] oa;
    logic [7:0] od;
    logic       aak, ast, aer;
    logic       bak, bst, ber;
    logic [7:0] ard, brd;
  } vec_t;

  localparam int NV = 26;
  vec_t v [NV];

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               nm, got, exp);
    end
  endtask

  task automatic idle_in();
    a_cyc = O; a_stb = O; a_we = O;
    a_addr = 2'd0; a_wd = 8'h00;
    b_cyc = O; b_stb = O; b_we = O;
    b_addr = 2'd0; b_wd = 8'h00;
    s_ack = O; s_stall = O; s_rd = 8'h00;
  endtask

  task automatic apply(input vec_t x);
    rst = x.rst;
    a_cyc = x.ac; a_stb = x.as; a_we = x.aw;
    a_addr = x.aa; a_wd = x.ad;
    b_cyc = x.bc; b_stb = x.bs; b_we = x.bw;
    b_addr = x.ba; b_wd = x.bd;
    s_ack = x.ack; s_stall = x.stl; s_rd = x.rd;
  endtask

  initial begin
    // rst, A{cyc,stb,we,addr,data}, B{...}, ack,stall,rdata
    // | grant, slave{cyc,stb,we,addr,data},
    //   A{ack,stall,err}, B{ack,stall,err}, A rd, B rd
    v[0]  = '{I, O,O,O,2'd0,8'h00, O,O,O,2'd0,8'h00, O,O,8'h00,
              2'b00, O,O,O,2'd0,8'h00, O,I,O, O,I,O, 8'h00,8'h00};
    v[1]  = '{O, I,I,I,2'd1,8'h5A, O,O,O,2'd0,8'h00, O,O,8'h00,
              2'b00, O,O,O,2'd0,8'h00, O,I,O, O,I,O, 8'h00,8'h00};
    v[2]  = '{O, I,I,I,2'd1,8'h5A, O,O,O,2'd0,8'h00, O,O,8'h00,
              2'b01, I,I,I,2'd1,8'h5A, O,O,O, O,I,O, 8'h00,8'h00};
    v[3]  = '{O, I,O,I,2'd1,8'h5A, O,O,O,2'd0,8'h00, I,O,8'h00,
              2'b01, I,O,I,2'd1,8'h5A, I,O,O, O,I,O, 8'h00,8'h00};
    v[4]  = '{O, O,O,O,2'd0,8'h00, O,O,O,2'd0,8'h00, O,O,8'h00,
              2'b01, O,O,O,2'd0,8'h00, O,O,O, O,I,O, 8'h00,8'h00};
    v[5]  = '{I, O,O,O,2'd0,8'h00, O,O,O,2'd0,8'h00, O,O,8'h00,
              2'b00, O,O,O,2'd0,8'h00, O,I,O, O,I,O, 8'h00,8'h00};
    v[6]  = '{O, I,O,O,2'd0,8'h00, I,O,O,2'd0,8'h00, O,O,8'h00,
              2'b00, O,O,O,2'd0,8'h00, O,I,O, O,I,O, 8'h00,8'h00};
    v[7]  = '{O, I,O,O,2'd0,8'h00, I,O,O,2'd0,8'h00, O,O,8'h00,
              2'b01, I,O,O,2'd0,8'h00, O,O,O, O,I,O, 8'h00,8'h00};
    v[8]  = '{O, O,O,O,2'd0,8'h00, I,O,O,2'd0,8'h00, O,O,8'h00,
              2'b01, O,O,O,2'd0,8'h00, O,O,O, O,I,O, 8'h00,8'h00};
    v[9]  = '{O, O,O,O,2'd0,8'h00, I,I,O,2'd2,8'h00, O,O,8'h00,
              2'b10, I,I,O,2'd2,8'h00, O,I,O, O,O,O, 8'h00,8'h00};
    v[10] = '{O, O,O,O,2'd0,8'h00, I,O,O,2'd2,8'h00, I,O,8'hC3,
              2'b10, I,O,O,2'd2,8'h00, O,I,O, I,O,O, 8'hC3,8'hC3};
    v[11] = '{O, O,O,O,2'd0,8'h00, O,O,O,2'd0,8'h00, O,O,8'h00,
              2'b10, O,O,O,2'd0,8'h00, O,I,O, O,O,O, 8'h00,8'h00};
    v[12] = '{O, I,O,O,2'd0,8'h00, I,O,O,2'd0,8'h00, O,O,8'h00,
              2'b00, O,O,O,2'd0,8'h00, O,I,O, O,I,O, 8'h00,8'h00};
    v[13] = '{O, I,O,O,2'd0,8'h00, I,O,O,2'd0,8'h00, O,O,8'h00,
              2'b01, I,O,O,2'd0,8'h00, O,O,O, O,I,O, 8'h00,8'h00};
    v[14] = '{O, I,I,I,2'd3,8'h11, I,O,O,2'd0,8'h00, O,I,8'h00,
              2'b01, I,I,I,2'd3,8'h11, O,I,O, O,I,O, 8'h00,8'h00};
    v[15] = v[14];
    v[16] = v[14];
    v[17] = '{O, I,I,I,2'd3,8'h11, I,O,O,2'd0,8'h00, O,O,8'h00,
              2'b01, I,I,I,2'd3,8'h11, O,O,O, O,I,O, 8'h00,8'h00};
    v[18] = v[17];
    v[18].rst = I;
    v[19] = '{O, I,I,I,2'd3,8'h11, I,O,O,2'd0,8'h00, O,O,8'h00,
              2'b00, O,O,O,2'd0,8'h00, O,I,O, O,I,O, 8'h00,8'h00};
    v[20] = v[17];
    v[21] = '{O, O,O,O,2'd0,8'h00, O,O,O,2'd0,8'h00, O,O,8'h00,
              2'b01, O,O,O,2'd0,8'h00, O,O,O, O,I,O, 8'h00,8'h00};
    v[22] = '{O, O,O,O,2'd0,8'h00, O,I,O,2'd1,8'h00, I,O,8'h00,
              2'b00, O,O,O,2'd0,8'h00, O,I,O, O,I,O, 8'h00,8'h00};
    v[23] = '{O, O,O,O,2'd0,8'h00, I,O,O,2'd0,8'h00, O,O,8'h00,
              2'b00, O,O,O,2'd0,8'h00, O,I,O, O,I,O, 8'h00,8'h00};
    v[24] = '{O, O,O,O,2'd0,8'h00, I,O,O,2'd0,8'h00, O,O,8'h00,
              2'b10, I,O,O,2'd0,8'h00, O,I,O, O,O,O, 8'h00,8'h00};
    v[25] = '{O, O,O,O,2'd0,8'h00, O,O,O,2'd0,8'h00, O,O,8'h00,
              2'b10, O,O,O,2'd0,8'h00, O,I,O, O,O,O, 8'h00,8'h00};

    rst = I;
    idle_in();
    repeat (2) @(posedge clk);

    for (int k = 0; k < NV; k++) begin
      @(negedge clk);
      apply(v[k]);
      #1;
      chk($sformatf("row%0d", k),
          64'({grant, wb_cyc, wb_stb, wb_we, wb_addr,
               wb_wd, a_ack, a_stall, a_err,
               b_ack, b_stall, b_err, a_rd, b_rd}),
          64'({v[k].g, v[k].c, v[k].s, v[k].w, v[k].oa,
               v[k].od, v[k].aak, v[k].ast, v[k].aer,
               v[k].bak, v[k].bst, v[k].ber,
               v[k].ard, v[k].brd}));
    end

`ifdef MAC_ARB_TIMEOUT_EN
    @(negedge clk);
    rst = I;
    idle_in();
    @(negedge clk);
    rst = O;
    a_cyc = I; a_stb = I;
    #1;
    chk("tmo_idle", 64'(grant), 64'(2'b00));
    for (int g = 1; g <= 9; g++) begin
      @(negedge clk);
      #1;
      chk($sformatf("tmo_err_g%0d", g),
          64'({grant, a_err}),
          64'({2'b01, (g == 9) ? I : O}));
    end
    @(negedge clk);
    #1;
    chk("tmo_abort",
        64'({wb_cyc, a_stall, a_err, a_ack}),
        64'({O, I, O, O}));
    @(negedge clk);
    a_cyc = O; a_stb = O;
    b_cyc = I;
    #1;
    chk("tmo_abort_hold", 64'(wb_cyc), 64'(O));
    begin
      bit seen = 1'b0;
      for (int t = 0; t < 6 && !seen; t++) begin
        @(negedge clk);
        #1;
        seen = (grant == 2'b10);
      end
      chk("tmo_b_grant", 64'(seen), 64'(I));
    end
`endif

    @(negedge clk);
    idle_in();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_wb_arbiter.md
Name: mac_wb_arbiter

Overview:
- Two-master round-robin arbiter sharing the MAC's single pipelined Wishbone slave port (2-bit address, 8-bit data).
- Sits between `mac` and its requesters: the existing `master` on port A, and a second requester on port B (e.g. frame loader or debug bridge).
- Grants the bus for a whole Wishbone cycle (cyc-locked) and routes ack/stall/data back only to the granted master.

Parameters:
- AW, 2, address width of the MAC register port.
- DW, 8, data width.
- TIMEOUT, 255, cycles without ack before abort. Used only with MAC_ARB_TIMEOUT_EN.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- i_a_wb_cyc, i_a_wb_stb, i_a_wb_we  input  1 each  master A control
- i_a_wb_addr  input  AW  master A address
- i_a_wb_data  input  DW  master A write data
- o_a_wb_ack, o_a_wb_stall, o_a_wb_err  output  1 each  master A responses
- o_a_wb_data  output  DW  read data to A
- i_b_wb_* / o_b_wb_*  same set as A, for master B
- o_wb_cyc, o_wb_stb, o_wb_we  output  1 each  to MAC slave
- o_wb_addr  output  AW  to MAC slave
- o_wb_data  output  DW  to MAC slave
- i_wb_ack, i_wb_stall  input  1 each  from MAC slave
- i_wb_data  input  DW  from MAC slave
- o_grant  output  2  one-hot current grant: 01=A, 10=B, 00=none

Behaviour:
- Interface: single clock clk; reset rst is synchronous and active-high.
- States: IDLE, GRANT_A, GRANT_B (plus ABORT with MAC_ARB_TIMEOUT_EN). State and priority pointer are registered; slave-side routing is combinational from the registered state.
- Priority pointer `last`: 1 bit, reset to B, so A wins first contention.
- IDLE:
  - All slave outputs are 0.
  - Both masters see stall=1, ack=0.
  - Only A cyc -> GRANT_A. Only B cyc -> GRANT_B.
  - Both cyc -> grant the master not equal to `last`.
  - Grant is visible one cycle after the request, so the first stb can be accepted at the earliest in cycle 2.
- GRANT_X:
  - o_wb_{cyc,stb,we,addr,data} follow master X combinationally.
  - o_x_ack = i_wb_ack; o_x_stall = i_wb_stall.
  - Other master: stall=1, ack=0, err=0.
  - Both o_a_wb_data and o_b_wb_data = i_wb_data (broadcast; only the ack is gated).
- Release: when X cyc=0 in GRANT_X:
  - `last` <= X.
  - Next state is GRANT_other if the other master's cyc=1 that same cycle (zero-idle handoff), else IDLE.
  - o_wb_cyc is already 0 in the release cycle, because it follows X.
- A master holds its grant for as long as cyc stays high; there is no preemption.
- Acks for stbs accepted during a grant are assumed to return before the master drops cyc (standard Wishbone). The arbiter does not count outstanding transactions.
- stb while not granted: ignored, master sees stall=1. Ack arriving in IDLE: dropped.
- Reset (including mid-transfer): state <= IDLE, last <= B, timeout counter cleared.
  - Reset values for all outputs: o_wb_* = 0, o_x_ack = 0, o_x_stall = 1, o_x_err = 0, o_grant = 00.

Optional Feature:
- Macro: MAC_ARB_TIMEOUT_EN.
- With macro:
  - A counter (width clog2(TIMEOUT+1)) clears on grant entry and on every i_wb_ack, and increments each cycle in GRANT_X.
  - When the count reaches TIMEOUT: o_x_err=1 for exactly one cycle and the state moves to ABORT.
  - ABORT: o_wb_cyc=0 and o_x_stall=1. Stay until X cyc=0, then go to IDLE with `last` <= X.
- Without macro: o_a_wb_err and o_b_wb_err are tied 0, there is no counter and no ABORT state, and a hung slave holds the grant forever.

Decomposition:
- Shared package mac_wb_pkg:
  - AW/DW localparams.
  - Arbiter state enum (IDLE, GRANT_A, GRANT_B, ABORT).
  - Grant encoding constants.
- One natural sub-module, mac_arb_wdt: the timeout counter, instantiated only under MAC_ARB_TIMEOUT_EN. The mux and FSM stay inline.

Test Plan:
- Reset -> o_grant=00, o_wb_cyc=0, o_a_wb_stall=o_b_wb_stall=1.
- A only: write addr=1 data=0x5A -> o_grant=01 next cycle; slave sees stb/we/addr=1/data=0x5A; A gets the ack; B stays ack=0 throughout.
- A and B assert cyc in the same cycle after reset -> A granted first. A drops cyc with B still requesting -> o_grant=10 on the next cycle with no IDLE cycle in between. Repeat the simultaneous request -> B is now `last`, so A wins again.
- Read by B, slave returns i_wb_data=0xC3 with ack -> o_b_wb_ack=1 and o_b_wb_data=0xC3; o_a_wb_ack=0.
- Slave stall=1 for 3 cycles during A's stb -> o_a_wb_stall mirrors it and stb is held. rst pulsed mid-burst -> next cycle o_grant=00 and o_wb_cyc=0.
- MAC_ARB_TIMEOUT_EN with TIMEOUT=8, slave never acks -> o_a_wb_err=1 for one cycle after 8 granted cycles; o_wb_cyc=0 in ABORT; after A drops cyc, a B request is granted.
